// File: rtl/s38417_bank_scan_stage.sv
// s38417_bank_scan_stage: three W-bit state banks scanned in the order A, B, C.
// Each bank word is compared against ref_data during its own scan cycle. The
// stage accumulates per-bank match flags and a total mismatch-bit count, then
// pulses done for the downstream output-select cone.
`timescale 1ns/1ps
module s38417_bank_scan_stage #(
  parameter int W  = 8,
  parameter int CW = 5
) (
  input  logic          CK,
  input  logic          RST,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [1:0]    wr_bank,
  input  logic [W-1:0]  wr_data,
  input  logic [W-1:0]  ref_data,
  input  logic          start,
  output logic [2:0]    sel,
  output logic [W-1:0]  mux_data,
  output logic [2:0]    match_vec,
  output logic [CW-1:0] mismatch_cnt,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SCAN_A = 3'd1,
    SCAN_B = 3'd2,
    SCAN_C = 3'd3,
    FIN    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  bank_a_q, bank_a_d;
  logic [W-1:0]  bank_b_q, bank_b_d;
  logic [W-1:0]  bank_c_q, bank_c_d;
  logic [2:0]    match_vec_q, match_vec_d;
  logic [CW-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [W-1:0]  diff;

  // Number of set bits in a word; the CW constraint keeps 3*W within range.
  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) begin
      n = n + CW'(v[i]);
    end
    return n;
  endfunction

  assign wr_ready     = (state_q == IDLE);
  assign done         = (state_q == FIN);
  assign match_vec    = match_vec_q;
  assign mismatch_cnt = mismatch_cnt_q;
  assign diff         = mux_data ^ ref_data;

  // Decode the one-hot bank select from the scan state and route the bank word.
  always_comb begin
    sel      = 3'b000;
    mux_data = '0;
    case (state_q)
      SCAN_A: begin
        sel      = 3'b001;
        mux_data = bank_a_q;
      end
      SCAN_B: begin
        sel      = 3'b010;
        mux_data = bank_b_q;
      end
      SCAN_C: begin
        sel      = 3'b100;
        mux_data = bank_c_q;
      end
      default: begin
        sel      = 3'b000;
        mux_data = '0;
      end
    endcase
  end

  // Next-state, bank write and compare/accumulate logic.
  always_comb begin
    state_d        = state_q;
    bank_a_d       = bank_a_q;
    bank_b_d       = bank_b_q;
    bank_c_d       = bank_c_q;
    match_vec_d    = match_vec_q;
    mismatch_cnt_d = mismatch_cnt_q;
    case (state_q)
      IDLE: begin
        // A write accepted with start lands on the same edge, so the scan sees it.
        if (wr_valid) begin
          case (wr_bank)
            2'd0:    bank_a_d = wr_data;
            2'd1:    bank_b_d = wr_data;
            2'd2:    bank_c_d = wr_data;
            default: ;
          endcase
        end
        if (start) begin
          state_d        = SCAN_A;
          match_vec_d    = 3'b000;
          mismatch_cnt_d = '0;
        end
      end
      SCAN_A: begin
        match_vec_d[0] = (diff == '0);
        mismatch_cnt_d = mismatch_cnt_q + popcount(diff);
        state_d        = SCAN_B;
      end
      SCAN_B: begin
        match_vec_d[1] = (diff == '0);
        mismatch_cnt_d = mismatch_cnt_q + popcount(diff);
        state_d        = SCAN_C;
      end
      SCAN_C: begin
        match_vec_d[2] = (diff == '0);
        mismatch_cnt_d = mismatch_cnt_q + popcount(diff);
        state_d        = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset aborts any scan in progress and clears the banks.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_q        <= IDLE;
      bank_a_q       <= '0;
      bank_b_q       <= '0;
      bank_c_q       <= '0;
      match_vec_q    <= 3'b000;
      mismatch_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      bank_a_q       <= bank_a_d;
      bank_b_q       <= bank_b_d;
      bank_c_q       <= bank_c_d;
      match_vec_q    <= match_vec_d;
      mismatch_cnt_q <= mismatch_cnt_d;
    end
  end

endmodule

// File: tb/tb_s38417_bank_scan_stage.sv
// Scoreboard bench for s38417_bank_scan_stage: the driver pushes expected scan
// words and results, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_s38417_bank_scan_stage;
  localparam int W  = 8;
  localparam int CW = 5;

  logic          CK = 1'b0;
  logic          RST;
  logic          wr_valid;
  logic          wr_ready;
  logic [1:0]    wr_bank;
  logic [W-1:0]  wr_data;
  logic [W-1:0]  ref_data;
  logic          start;
  logic [2:0]    sel;
  logic [W-1:0]  mux_data;
  logic [2:0]    match_vec;
  logic [CW-1:0] mismatch_cnt;
  logic          done;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  logic [W-1:0]    bank_m [3];
  logic [2:0]      exp_sel_q [$];
  logic [W-1:0]    exp_mux_q [$];
  logic [CW+2:0]   exp_res_q [$];
  logic [CW+2:0]   mon_e;

  s38417_bank_scan_stage #(.W(W), .CW(CW)) dut (
    .CK(CK), .RST(RST), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_bank(wr_bank), .wr_data(wr_data), .ref_data(ref_data), .start(start),
    .sel(sel), .mux_data(mux_data), .match_vec(match_vec),
    .mismatch_cnt(mismatch_cnt), .done(done)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every scan word and every done pulse against the scoreboard.
  always @(negedge CK) begin
    if (mon_en) begin
      if (sel !== 3'b000) begin
        if (exp_sel_q.size() == 0) begin
          check("unexpected_sel", {29'd0, sel}, 32'd0);
        end else begin
          check("sel", {29'd0, sel}, {29'd0, exp_sel_q.pop_front()});
          check("mux_data", {24'd0, mux_data}, {24'd0, exp_mux_q.pop_front()});
        end
      end else begin
        check("mux_idle", {24'd0, mux_data}, 32'd0);
      end
      if (done !== 1'b0) begin
        if (exp_res_q.size() == 0) begin
          check("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          mon_e = exp_res_q.pop_front();
          check("match_vec", {29'd0, match_vec}, {29'd0, mon_e[CW+2:CW]});
          check("mismatch_cnt", {27'd0, mismatch_cnt}, {27'd0, mon_e[CW-1:0]});
        end
      end
    end
  end

  // Single idle-cycle write; called just after a rising edge.
  task automatic do_write(input logic [1:0] b, input logic [W-1:0] d);
    wr_valid = 1'b1;
    wr_bank  = b;
    wr_data  = d;
    check("wr_ready_idle", {31'd0, wr_ready}, 32'd1);
    if (b != 2'd3) bank_m[b] = d;
    @(posedge CK); #1;
    wr_valid = 1'b0;
  endtask

  // One full scan (5 cycles incl. return to IDLE), optional write with start,
  // optional write+start attempt during SCAN_B which must be ignored.
  task automatic do_scan(input logic [W-1:0] r0, input logic [W-1:0] r1,
                         input logic [W-1:0] r2, input bit sw,
                         input logic [1:0] sb, input logic [W-1:0] sd,
                         input bit mid);
    logic [W-1:0] r [3];
    logic [W-1:0] d;
    logic [2:0]   mv;
    int           cnt;
    r[0] = r0; r[1] = r1; r[2] = r2;
    start    = 1'b1;
    wr_valid = sw;
    wr_bank  = sb;
    wr_data  = sd;
    if (sw && sb != 2'd3) bank_m[sb] = sd;
    mv  = 3'b000;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      d     = bank_m[i] ^ r[i];
      cnt   = cnt + $countones(d);
      mv[i] = (d == '0);
      exp_sel_q.push_back(3'b001 << i);
      exp_mux_q.push_back(bank_m[i]);
    end
    exp_res_q.push_back({mv, cnt[CW-1:0]});
    @(posedge CK); #1;
    start    = 1'b0;
    wr_valid = 1'b0;
    ref_data = r0;
    @(posedge CK); #1;
    ref_data = r1;
    if (mid) begin
      wr_valid = 1'b1;
      wr_bank  = 2'd0;
      wr_data  = ~bank_m[0];
      start    = 1'b1;
      check("wr_ready_busy", {31'd0, wr_ready}, 32'd0);
    end
    @(posedge CK); #1;
    wr_valid = 1'b0;
    start    = 1'b0;
    ref_data = r2;
    @(posedge CK); #1;
    ref_data = W'($urandom);
    @(posedge CK); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] r0, r1, r2;
    int nw;
    RST = 1'b1; wr_valid = 1'b0; wr_bank = 2'd0; wr_data = '0;
    ref_data = '0; start = 1'b0;
    for (int i = 0; i < 3; i++) bank_m[i] = '0;
    repeat (3) @(posedge CK);
    #1;
    // Reset state
    check("rst_sel", {29'd0, sel}, 32'd0);
    check("rst_mux", {24'd0, mux_data}, 32'd0);
    check("rst_match", {29'd0, match_vec}, 32'd0);
    check("rst_cnt", {27'd0, mismatch_cnt}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    RST = 1'b0;
    mon_en = 1'b1;
    @(posedge CK); #1;

    // All banks equal to reference
    do_write(2'd0, 8'h5A); do_write(2'd1, 8'h5A); do_write(2'd2, 8'h5A);
    do_scan(8'h5A, 8'h5A, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0);
    // Mixed banks: only A matches, 12 differing bits
    do_write(2'd0, 8'h00); do_write(2'd1, 8'hFF); do_write(2'd2, 8'h0F);
    do_scan(8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    // Maximum mismatch count
    do_write(2'd0, 8'hFF); do_write(2'd1, 8'hFF); do_write(2'd2, 8'hFF);
    do_scan(8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);
    // Write accepted together with start
    do_scan(8'h00, 8'h33, 8'h00, 1'b1, 2'd1, 8'h33, 1'b0);
    // Write and start during SCAN_B are ignored, then confirm bank A unchanged
    do_scan(8'h12, 8'h34, 8'h56, 1'b0, 2'd0, 8'h00, 1'b1);
    do_scan(bank_m[0], bank_m[1], bank_m[2], 1'b0, 2'd0, 8'h00, 1'b0);
    // Reserved bank write leaves banks untouched
    do_write(2'd3, 8'hC3);
    do_scan(bank_m[0], 8'h00, bank_m[2], 1'b0, 2'd0, 8'h00, 1'b0);
    // Reserved bank write together with start
    do_scan(bank_m[0], bank_m[1], 8'hC3, 1'b1, 2'd3, 8'hC3, 1'b0);

    // Reset during SCAN_B aborts the scan without done
    do_write(2'd0, 8'hA1); do_write(2'd1, 8'hB2); do_write(2'd2, 8'hC4);
    exp_sel_q.push_back(3'b001); exp_mux_q.push_back(bank_m[0]);
    exp_sel_q.push_back(3'b010); exp_mux_q.push_back(bank_m[1]);
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    @(posedge CK); #1;
    RST = 1'b1;
    @(posedge CK); #1;
    RST = 1'b0;
    for (int i = 0; i < 3; i++) bank_m[i] = '0;
    check("abort_sel", {29'd0, sel}, 32'd0);
    check("abort_match", {29'd0, match_vec}, 32'd0);
    check("abort_cnt", {27'd0, mismatch_cnt}, 32'd0);
    repeat (3) @(posedge CK);
    #1;
    do_scan(8'h00, 8'h00, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0);

    // Randomized scans with random writes and per-cycle reference words
    for (int k = 0; k < 30; k++) begin
      nw = $urandom_range(0, 2);
      for (int j = 0; j < nw; j++) begin
        do_write(2'($urandom_range(0, 3)), W'($urandom));
      end
      r0 = ($urandom_range(0, 1) != 0) ? bank_m[0] : W'($urandom);
      r1 = ($urandom_range(0, 1) != 0) ? bank_m[1] : W'($urandom);
      r2 = ($urandom_range(0, 1) != 0) ? bank_m[2] : W'($urandom);
      do_scan(r0, r1, r2, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
              W'($urandom), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(posedge CK);
    #1;
    check("queue_drain", exp_sel_q.size() + exp_res_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
